// File: rtl/branch_kill_fifo.sv
// In-order FIFO whose entries carry a speculative branch mask; applies branch clean and mispredict kill.
// Optional occupancy output is enabled with `define BRANCH_KILL_FIFO_COUNT_EN.
module branch_kill_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int NUM_TAGS   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wen,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [NUM_TAGS-1:0]         wmask,
  input  logic                        ren,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [NUM_TAGS-1:0]         rmask,
  output logic                        full,
  output logic                        empty,
`ifdef BRANCH_KILL_FIFO_COUNT_EN
  output logic [$clog2(DEPTH):0]      count,
`endif
  input  logic                        br_broadcast,
  input  logic [$clog2(NUM_TAGS)-1:0] br_tag,
  input  logic                        br_clean,
  input  logic                        flush
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [NUM_TAGS-1:0]   mask_mem_r [DEPTH];

  logic [PW-1:0]       wptr_r;
  logic [PW-1:0]       rptr_r;
  logic [PW-1:0]       wptr_nxt_s;
  logic [PW-1:0]       rptr_nxt_s;
  logic [PW-1:0]       occ_s;
  logic [PW-1:0]       scan_ptr_s;
  logic [PW-1:0]       kill_ptr_s;
  logic                kill_hit_s;
  logic                hit_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic                write_s;
  logic                do_clean_s;
  logic                do_kill_s;
  logic [NUM_TAGS-1:0] tag_bit_s;
  logic [NUM_TAGS-1:0] clean_bit_s;
  logic [NUM_TAGS-1:0] wmask_eff_s;

  assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty_s = (wptr_r == rptr_r);
  assign occ_s   = wptr_r - rptr_r;

  assign tag_bit_s   = {{(NUM_TAGS-1){1'b0}}, 1'b1} << br_tag;
  assign do_clean_s  = br_broadcast & br_clean;
  assign do_kill_s   = br_broadcast & ~br_clean;
  assign clean_bit_s = do_clean_s ? tag_bit_s : {NUM_TAGS{1'b0}};
  assign wmask_eff_s = wmask & ~clean_bit_s;
  assign push_s      = wen & ~full_s;
  assign pop_s       = ren & ~empty_s;

  // Oldest valid entry carrying the resolved tag; scanning youngest-first lets the oldest hit win.
  always_comb begin
    kill_hit_s = 1'b0;
    kill_ptr_s = wptr_r;
    scan_ptr_s = rptr_r;
    hit_s      = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_ptr_s = rptr_r + PW'(i);
      hit_s      = (PW'(i) < occ_s) && mask_mem_r[scan_ptr_s[AW-1:0]][br_tag];
      kill_hit_s = kill_hit_s | hit_s;
      kill_ptr_s = hit_s ? scan_ptr_s : kill_ptr_s;
    end
  end

  // Next pointer values and write qualification: flush, then kill truncation, then normal traffic.
  always_comb begin
    write_s    = push_s;
    rptr_nxt_s = pop_s ? (rptr_r + PTR_ONE) : rptr_r;
    wptr_nxt_s = wptr_r;
    if (flush) begin
      write_s    = 1'b0;
      rptr_nxt_s = PTR_ZERO;
      wptr_nxt_s = PTR_ZERO;
    end else if (do_kill_s && kill_hit_s) begin
      write_s = 1'b0;
      if (pop_s && (kill_ptr_s == rptr_r)) begin
        wptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
        wptr_nxt_s = kill_ptr_s;
      end
    end else begin
      write_s    = push_s & ~(do_kill_s & wmask[br_tag]);
      wptr_nxt_s = write_s ? (wptr_r + PTR_ONE) : wptr_r;
    end
  end

  // Pointer registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= PTR_ZERO;
      rptr_r <= PTR_ZERO;
    end else begin
      wptr_r <= wptr_nxt_s;
      rptr_r <= rptr_nxt_s;
    end
  end

  // Entry storage: clean clears the tag everywhere, then the new entry (if any) overrides its slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_clean_s) begin
        mask_mem_r[i] <= mask_mem_r[i] & ~tag_bit_s;
      end
    end
    if (write_s) begin
      data_mem_r[wptr_r[AW-1:0]] <= wdata;
      mask_mem_r[wptr_r[AW-1:0]] <= wmask_eff_s;
    end
  end

  assign rdata = data_mem_r[rptr_r[AW-1:0]];
  assign rmask = mask_mem_r[rptr_r[AW-1:0]] & ~clean_bit_s;
  assign full  = full_s;
  assign empty = empty_s;
`ifdef BRANCH_KILL_FIFO_COUNT_EN
  assign count = occ_s;
`endif

  a_tag_legal: assert property (@(posedge clk) disable iff (!rst_n)
    br_broadcast |-> (32'(br_tag) < 32'(NUM_TAGS)));

endmodule
